// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-port RAM between instruction fetch and data access,
// with data-first fairness, a per-access wait timeout and abort-on-drop hit suppression.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] BAD_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    state_t state;
    logic last_d, is_wr, dropped, grant_d, owner_req, timed_out, keep;
    logic [7:0] cnt;
    always_comb begin
        grant_d   = (dREN | dWEN) & ~(iREN & last_d);
        owner_req = (state == BUSY_D) ? (dREN | dWEN) : iREN;
        timed_out = ~ram_ready & (cnt + 8'd1 == 8'(TIMEOUT));
        keep      = ~dropped & owner_req;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            is_wr     <= 1'b0;
            dropped   <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            ram_addr  <= '0;
            ram_store <= '0;
        end else begin
            case (state)
                IDLE: if (iREN | dREN | dWEN) begin
                    state    <= grant_d ? BUSY_D : BUSY_I;
                    last_d   <= grant_d;
                    is_wr    <= grant_d & dWEN;
                    ram_addr <= grant_d ? daddr : iaddr;
                    ram_ren  <= ~(grant_d & dWEN);
                    ram_wen  <= grant_d & dWEN;
                    cnt      <= '0;
                    dropped  <= 1'b0;
                    if (grant_d & dWEN) ram_store <= dstore;
                end
                BUSY_I, BUSY_D: begin
                    // a requester that lets go mid-access still lets the RAM finish, but loses its hit
                    dropped <= ~keep;
                    if (!ram_ready) cnt <= cnt + 8'd1;
                    if (ram_ready | timed_out) begin
                        state   <= DONE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        err     <= err | timed_out;
                        ihit    <= keep & (state == BUSY_I);
                        dhit    <= keep & (state == BUSY_D);
                        if (keep && state == BUSY_I) iload <= ram_ready ? ram_load : BAD_WORD;
                        if (keep && state == BUSY_D && !is_wr) dload <= ram_ready ? ram_load : BAD_WORD;
                    end
                end
                default: begin
                    state <= IDLE;
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;
    localparam int TMO = 5;
    logic CLK = 0, nRST = 0, iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ram_load;
    logic ihit, dhit, ram_ren, ram_wen, err;
    logic [31:0] iload, dload, ram_addr, ram_store;
    int checks = 0, fails = 0;
    int ram_delay = 1, busy_n = 0;
    int ihits = 0, dhits = 0, both = 0, ren_cyc = 0, wen_cyc = 0, wr_cnt = 0;
    logic [31:0] wr_addr = 0, wr_data = 0;
    bit hit_q[$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(TMO), .BAD_WORD(BAD)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready), .err(err)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C220004 : {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction
    assign ram_load = mem_val(ram_addr);

    // RAM responder and activity monitor; ready is raised on the ram_delay-th strobe cycle (0 = never)
    always @(posedge CLK) begin
        #1;
        if (ihit) begin ihits++; hit_q.push_back(1'b0); end
        if (dhit) begin dhits++; hit_q.push_back(1'b1); end
        if (ihit && dhit) both++;
        if (ram_ren) ren_cyc++;
        if (ram_wen) wen_cyc++;
        if (ram_ren || ram_wen) begin
            busy_n++;
            ram_ready = (ram_delay != 0) && (busy_n == ram_delay);
        end else begin
            busy_n = 0;
            ram_ready = 0;
        end
        if (ram_ready && ram_wen) begin wr_addr = ram_addr; wr_data = ram_store; wr_cnt++; end
    end

    task automatic clear_mon();
        ihits = 0; dhits = 0; both = 0; ren_cyc = 0; wen_cyc = 0; wr_cnt = 0;
        hit_q.delete();
    endtask

    // raise the requested lines and drop each one on its own hit, within a cycle budget
    task automatic serve(input bit ri, input bit rd, input bit wr, output bit to);
        bit pi = ri, pd = rd | wr;
        int n = 0;
        iREN = ri; dREN = rd; dWEN = wr;
        while ((pi || pd) && n < 40) begin
            @(negedge CLK);
            n++;
            if (ihit) begin pi = 0; iREN = 0; end
            if (dhit) begin pd = 0; dREN = 0; dWEN = 0; end
        end
        to = pi | pd;
        iREN = 0; dREN = 0; dWEN = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 0;
        repeat (3) @(negedge CLK);
        checks++; if ({ihit, dhit, ram_ren, ram_wen, err} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b want 00000", {ihit, dhit, ram_ren, ram_wen, err}); end
        checks++; if ({iload, dload} !== 64'h0) begin fails++; $display("FAIL reset_loads got %h want 0", {iload, dload}); end
        checks++; if ({ram_addr, ram_store} !== 64'h0) begin fails++; $display("FAIL reset_ram got %h want 0", {ram_addr, ram_store}); end
        nRST = 1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_fetch();
        int n = 0;
        clear_mon();
        ram_delay = 1; iaddr = 32'h40; iREN = 1;
        while (!ihit && n < 20) begin @(negedge CLK); n++; end
        iREN = 0;
        checks++; if (n + 1 !== 3) begin fails++; $display("FAIL fetch_latency got %0d want 3", n + 1); end
        checks++; if (iload !== 32'h8C220004) begin fails++; $display("FAIL fetch_iload got %h want 8c220004", iload); end
        repeat (4) @(negedge CLK);
        checks++; if (ren_cyc !== 1) begin fails++; $display("FAIL fetch_ren_cycles got %0d want 1", ren_cyc); end
        checks++; if (ihits !== 1 || dhits !== 0) begin fails++; $display("FAIL fetch_hits got i=%0d d=%0d want i=1 d=0", ihits, dhits); end
    endtask

    task automatic test_priority();
        bit to;
        clear_mon();
        ram_delay = 2; iaddr = 32'h44; daddr = 32'h100;
        serve(1, 1, 0, to);
        checks++; if (to || hit_q.size() != 2 || hit_q[0] !== 1'b1) begin fails++; $display("FAIL prio_data_first got to=%0d n=%0d first=%0d want 0 2 1", to, hit_q.size(), hit_q.size() ? hit_q[0] : 1'b0); end
        checks++; if (dload !== mem_val(32'h100) || iload !== mem_val(32'h44)) begin fails++; $display("FAIL prio_loads got %h %h want %h %h", dload, iload, mem_val(32'h100), mem_val(32'h44)); end
        daddr = 32'h104;
        serve(0, 1, 0, to);
        clear_mon();
        iaddr = 32'h48; daddr = 32'h108;
        serve(1, 1, 0, to);
        checks++; if (to || hit_q.size() != 2 || hit_q[0] !== 1'b0) begin fails++; $display("FAIL prio_fetch_after_data got to=%0d n=%0d first=%0d want 0 2 0", to, hit_q.size(), hit_q.size() ? hit_q[0] : 1'b1); end
        checks++; if (both !== 0) begin fails++; $display("FAIL prio_both_hits got %0d want 0", both); end
    endtask

    task automatic test_write();
        bit to;
        clear_mon();
        ram_delay = 4; daddr = 32'h200; dstore = 32'hDEADBEEF;
        serve(0, 0, 1, to);
        checks++; if (to || wen_cyc !== 4 || ren_cyc !== 0) begin fails++; $display("FAIL write_strobe got to=%0d wen=%0d ren=%0d want 0 4 0", to, wen_cyc, ren_cyc); end
        checks++; if (wr_addr !== 32'h200 || wr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL write_data got %h %h want 200 deadbeef", wr_addr, wr_data); end
        checks++; if (dhits !== 1 || dload !== mem_val(32'h108)) begin fails++; $display("FAIL write_hit got %0d %h want 1 %h", dhits, dload, mem_val(32'h108)); end
        clear_mon();
        ram_delay = 2; daddr = 32'h204; dstore = 32'h12345678;
        serve(0, 1, 1, to);
        checks++; if (wen_cyc !== 2 || ren_cyc !== 0 || wr_data !== 32'h12345678) begin fails++; $display("FAIL rw_is_write got wen=%0d ren=%0d %h want 2 0 12345678", wen_cyc, ren_cyc, wr_data); end
    endtask

    task automatic test_timeout();
        bit to;
        clear_mon();
        ram_delay = 0; daddr = 32'h300;
        serve(0, 1, 0, to);
        checks++; if (to || ren_cyc !== TMO || dhits !== 1) begin fails++; $display("FAIL timeout_cycles got to=%0d ren=%0d hits=%0d want 0 %0d 1", to, ren_cyc, dhits, TMO); end
        checks++; if (dload !== BAD || err !== 1'b1) begin fails++; $display("FAIL timeout_bad got %h err=%b want %h 1", dload, err, BAD); end
        ram_delay = 1; iaddr = 32'h50;
        serve(1, 0, 0, to);
        checks++; if (err !== 1'b1 || iload !== mem_val(32'h50)) begin fails++; $display("FAIL timeout_sticky got err=%b %h want 1 %h", err, iload, mem_val(32'h50)); end
    endtask

    task automatic test_abort();
        bit to;
        clear_mon();
        ram_delay = 4; iaddr = 32'h80; iREN = 1;
        repeat (2) @(negedge CLK);
        iREN = 0;
        repeat (8) @(negedge CLK);
        checks++; if (ihits !== 0 || ren_cyc !== 4) begin fails++; $display("FAIL abort_fetch got hits=%0d ren=%0d want 0 4", ihits, ren_cyc); end
        checks++; if (iload !== mem_val(32'h50)) begin fails++; $display("FAIL abort_iload got %h want %h", iload, mem_val(32'h50)); end
        clear_mon();
        ram_delay = 0; daddr = 32'h400; dREN = 1;
        repeat (2) @(negedge CLK);
        nRST = 0; dREN = 0;
        #1;
        checks++; if ({ihit, dhit, ram_ren, ram_wen, err} !== 5'b0 || {iload, dload, ram_addr, ram_store} !== 128'h0) begin fails++; $display("FAIL abort_reset got %b %h want 0", {ihit, dhit, ram_ren, ram_wen, err}, {iload, dload, ram_addr, ram_store}); end
        @(negedge CLK);
        nRST = 1;
        repeat (5) @(negedge CLK);
        checks++; if (dhits !== 0) begin fails++; $display("FAIL abort_reset_hit got %0d want 0", dhits); end
        clear_mon();
        ram_delay = 1; iaddr = 32'h84; daddr = 32'h404;
        serve(1, 1, 0, to);
        checks++; if (to || hit_q.size() != 2 || hit_q[0] !== 1'b1) begin fails++; $display("FAIL reset_last_grant got to=%0d n=%0d want data first", to, hit_q.size()); end
    endtask

    task automatic test_random();
        bit to, ri, rd, wr, ok, last_d = 0, exp_err = 0;
        logic [31:0] exp_i = 0, exp_d = 0, ia, da, ds;
        int delay;
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        for (int k = 0; k < 40; k++) begin
            clear_mon();
            ri = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            if (!ri && !rd && !wr) ri = 1;
            delay = $urandom_range(0, 7);
            ok = delay >= 1 && delay <= TMO;
            ia = $urandom; da = $urandom; ds = $urandom;
            iaddr = ia; daddr = da; dstore = ds; ram_delay = delay;
            serve(ri, rd, wr, to);
            if (ri) exp_i = ok ? mem_val(ia) : BAD;
            if (rd && !wr) exp_d = ok ? mem_val(da) : BAD;
            if (!ok) exp_err = 1;
            checks++; if (to || hit_q.size() != int'(ri) + int'(rd | wr)) begin fails++; $display("FAIL rand_hits[%0d] got to=%0d n=%0d", k, to, hit_q.size()); end
            else if (ri && (rd || wr)) begin
                checks++; if (hit_q[0] !== !last_d) begin fails++; $display("FAIL rand_order[%0d] got first=%0d want %0d", k, hit_q[0], !last_d); end
            end
            if (!(ri && (rd || wr))) last_d = rd | wr;
            checks++; if (iload !== exp_i || dload !== exp_d || err !== exp_err) begin fails++; $display("FAIL rand_state[%0d] got %h %h %b want %h %h %b", k, iload, dload, err, exp_i, exp_d, exp_err); end
            checks++; if (wr_cnt != int'(wr && ok) || (wr && ok && (wr_addr !== da || wr_data !== ds)) || (wr && ren_cyc != 0 && !ri)) begin fails++; $display("FAIL rand_write[%0d] got cnt=%0d %h %h want %h %h", k, wr_cnt, wr_addr, wr_data, da, ds); end
            checks++; if (both !== 0) begin fails++; $display("FAIL rand_both[%0d] got %0d want 0", k, both); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_timeout();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
